// File: rtl/gf180mcu_osu_sc_gp12t3v3__rstgen_1_if.sv
// Reset-generator status/request bundle.
//   REQ   : soft-reset request into the generator
//   RN    : active-low downstream reset
//   BUSY  : high while RN is low
//   DONE  : one-cycle pulse after RN rises
//   STATE : generator state (RESET=0, SYNC=1, STRETCH=2, RUN=3)
// master = the reset generator, slave = the consumer.
interface gf180mcu_osu_sc_gp12t3v3__rstgen_1_if;
  logic       REQ;
  logic       RN;
  logic       BUSY;
  logic       DONE;
  logic [1:0] STATE;

  modport master (input REQ, output RN, output BUSY, output DONE, output STATE);
  modport slave  (output REQ, input RN, input BUSY, input DONE, input STATE);
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3__rstgen_1.sv
// Reset generator: synchronizes the release of an asynchronous active-high
// reset R, then stretches the downstream active-low reset RN for a fixed
// number of CLK edges before releasing it.
//   CLK : clock, all state changes on rising edge
//   R   : asynchronous active-high reset (assertion is immediate)
//   bus : REQ in; RN/BUSY/DONE/STATE out (see interface file)
// Parameters: SYNC_STAGES (2..4), STRETCH_CYCLES (1..255).
// Optional feature macro RSTGEN_SOFTREQ_EN: when defined, REQ in RUN
// restarts the stretch phase; when undefined REQ is ignored and RUN is
// terminal until R asserts.
module gf180mcu_osu_sc_gp12t3v3__rstgen_1 #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 8
) (
  input  logic CLK,
  input  logic R,
  gf180mcu_osu_sc_gp12t3v3__rstgen_1_if.master bus
);

  typedef enum logic [1:0] {
    S_RESET   = 2'd0,
    S_SYNC    = 2'd1,
    S_STRETCH = 2'd2,
    S_RUN     = 2'd3
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(STRETCH_CYCLES - 1);

  state_e                 state, state_nxt;
  logic [SYNC_STAGES-1:0] chain, chain_nxt;
  logic [7:0]             cnt, cnt_nxt;
  logic                   rn_q, done_q;
  logic                   soft_req;

`ifdef RSTGEN_SOFTREQ_EN
  assign soft_req = bus.REQ;
`else
  logic unused_req;
  assign unused_req = bus.REQ;
  assign soft_req   = 1'b0;
`endif

  always_comb begin
    // Chain fills with ones after R release; stays all-ones afterwards.
    chain_nxt = {chain[SYNC_STAGES-2:0], 1'b1};
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_RESET: state_nxt = S_SYNC;
      S_SYNC: begin
        // Leave SYNC on the edge the last synchronizer flop goes high.
        if (chain_nxt[SYNC_STAGES-1]) begin
          state_nxt = S_STRETCH;
          cnt_nxt   = 8'd0;
        end
      end
      S_STRETCH: begin
        // Holding at CNT_LAST doubles as saturation; REQ is ignored here.
        if (cnt == CNT_LAST) state_nxt = S_RUN;
        else                 cnt_nxt   = cnt + 8'd1;
      end
      S_RUN: begin
        if (soft_req) begin
          state_nxt = S_STRETCH;
          cnt_nxt   = 8'd0;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge CLK or posedge R) begin
    if (R) begin
      state  <= S_RESET;
      chain  <= '0;
      cnt    <= 8'd0;
      rn_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      chain  <= chain_nxt;
      cnt    <= cnt_nxt;
      // RN decoded from next state so it is a clean flop output.
      rn_q   <= (state_nxt == S_RUN);
      done_q <= (state == S_STRETCH) && (state_nxt == S_RUN);
    end
  end

  assign bus.RN    = rn_q;
  assign bus.BUSY  = ~rn_q;
  assign bus.DONE  = done_q;
  assign bus.STATE = state;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__rstgen_1.sv
// Directed bench for the reset generator: default instance u0 and a
// SYNC_STAGES=3 / STRETCH_CYCLES=1 instance u1 sharing the clock.
module tb_gf180mcu_osu_sc_gp12t3v3__rstgen_1;

  logic CLK = 1'b0;
  logic R0, R1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_gp12t3v3__rstgen_1_if bus0();
  gf180mcu_osu_sc_gp12t3v3__rstgen_1_if bus1();

  gf180mcu_osu_sc_gp12t3v3__rstgen_1 u0 (.CLK(CLK), .R(R0), .bus(bus0));
  gf180mcu_osu_sc_gp12t3v3__rstgen_1 #(.SYNC_STAGES(3), .STRETCH_CYCLES(1))
    u1 (.CLK(CLK), .R(R1), .bus(bus1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1ns after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    R0 = 1'b1; R1 = 1'b1;
    bus0.REQ = 1'b0; bus1.REQ = 1'b0;

    // Reset held for 3 cycles
    repeat (3) tick();
    chk("rst_rn",    32'(bus0.RN), 0);
    chk("rst_busy",  32'(bus0.BUSY), 1);
    chk("rst_done",  32'(bus0.DONE), 0);
    chk("rst_state", 32'(bus0.STATE), 0);

    // Release: SYNC at edge 1, STRETCH at 2..9, RUN at 10
    R0 = 1'b0;
    tick();
    chk("e1_state", 32'(bus0.STATE), 1);
    chk("e1_rn",    32'(bus0.RN), 0);
    tick();
    chk("e2_state", 32'(bus0.STATE), 2);
    for (int k = 3; k <= 9; k++) begin
      tick();
      chk($sformatf("e%0d_rn", k), 32'(bus0.RN), 0);
      chk($sformatf("e%0d_state", k), 32'(bus0.STATE), 2);
      chk($sformatf("e%0d_done", k), 32'(bus0.DONE), 0);
    end
    tick();
    chk("e10_rn",    32'(bus0.RN), 1);
    chk("e10_busy",  32'(bus0.BUSY), 0);
    chk("e10_done",  32'(bus0.DONE), 1);
    chk("e10_state", 32'(bus0.STATE), 3);
    tick();
    chk("e11_done", 32'(bus0.DONE), 0);
    chk("e11_rn",   32'(bus0.RN), 1);

    // Short asynchronous R pulse (3ns of a 10ns period) in RUN
    #1 R0 = 1'b1;
    #1;
    chk("apulse_rn",    32'(bus0.RN), 0);
    chk("apulse_busy",  32'(bus0.BUSY), 1);
    chk("apulse_state", 32'(bus0.STATE), 0);
    #2 R0 = 1'b0;
    #1;
    chk("apulse_after_rn", 32'(bus0.RN), 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk($sformatf("ap_e%0d_rn", k), 32'(bus0.RN), 0);
    end
    tick();
    chk("ap_e10_rn",   32'(bus0.RN), 1);
    chk("ap_e10_done", 32'(bus0.DONE), 1);
    tick();

`ifdef RSTGEN_SOFTREQ_EN
    // One-cycle soft request in RUN
    bus0.REQ = 1'b1;
    tick();
    bus0.REQ = 1'b0;
    chk("sreq_rn",    32'(bus0.RN), 0);
    chk("sreq_state", 32'(bus0.STATE), 2);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("sreq_e%0d_rn", k), 32'(bus0.RN), 0);
    end
    tick();
    chk("sreq_e8_rn",   32'(bus0.RN), 1);
    chk("sreq_e8_done", 32'(bus0.DONE), 1);
    tick();

    // REQ pulse at stretch edge 4 must not extend the stretch
    bus0.REQ = 1'b1;
    tick();
    bus0.REQ = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 4) bus0.REQ = 1'b1;
      tick();
      bus0.REQ = 1'b0;
      chk($sformatf("sext_e%0d_rn", k), 32'(bus0.RN), 0);
    end
    tick();
    chk("sext_e8_rn",   32'(bus0.RN), 1);
    chk("sext_e8_done", 32'(bus0.DONE), 1);
    tick();
`else
    // REQ ignored: RUN is terminal
    bus0.REQ = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("noreq_c%0d_rn", k), 32'(bus0.RN), 1);
      chk($sformatf("noreq_c%0d_done", k), 32'(bus0.DONE), 0);
    end
    bus0.REQ = 1'b0;
`endif

    // u1: SYNC_STAGES=3, STRETCH_CYCLES=1 -> RN rises at edge 4
    R1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("p_e%0d_rn", k), 32'(bus1.RN), 0);
    end
    chk("p_e3_state", 32'(bus1.STATE), 2);
    tick();
    chk("p_e4_rn",   32'(bus1.RN), 1);
    chk("p_e4_done", 32'(bus1.DONE), 1);
    tick();

    // Abort mid-SYNC: reassert R after edge 2
    R1 = 1'b1;
    tick();
    R1 = 1'b0;
    tick();
    tick();
    chk("ab_e2_state", 32'(bus1.STATE), 1);
    R1 = 1'b1;
    #1;
    chk("ab_rn",    32'(bus1.RN), 0);
    chk("ab_state", 32'(bus1.STATE), 0);
    tick();
    chk("ab_hold_rn",    32'(bus1.RN), 0);
    chk("ab_hold_state", 32'(bus1.STATE), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gf180mcu_osu_sc_gp12t3v3__rstgen_1.md
GF180MCU_OSU_SC_GP12T3V3__RSTGEN_1 -- requirements
Module: gf180mcu_osu_sc_gp12t3v3__rstgen_1

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops (legal range 2..4).
REQ-002 The block SHALL have parameter STRETCH_CYCLES, default 8, the number of CLK rising edges RN is held low after synchronization (legal range 1..255).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 CLK  input  1  clock; all state updates occur on its rising edge.
REQ-005 R  input  1  asynchronous active-high reset.
REQ-006 REQ  input  1  synchronous soft-reset request, sampled on CLK rising edge.
REQ-007 RN  output  1  active-low reset for downstream dffrn cells.
REQ-008 BUSY  output  1  high whenever RN is low.
REQ-009 DONE  output  1  one-cycle pulse on the edge where RN returns high.
REQ-010 STATE  output  2  current state encoding: RESET=0, SYNC=1, STRETCH=2, RUN=3.

Function
REQ-011 Internal state SHALL include a SYNC_STAGES-bit shift chain, an 8-bit stretch counter and a 2-bit state register.
REQ-012 The block SHALL implement the states RESET, SYNC, STRETCH and RUN.
REQ-013 RESET -> SYNC SHALL occur on the first CLK rising edge with R low; the shift chain shifts in 1 on every edge with R low.
REQ-014 SYNC -> STRETCH SHALL occur on the edge where the last chain flop becomes 1, i.e. the SYNC_STAGES-th edge after R falls; the counter loads 0 on that edge.
REQ-015 In STRETCH the counter SHALL increment by 1 on each edge; on the edge where the counter equals STRETCH_CYCLES-1 the state SHALL become RUN.
REQ-016 RN SHALL be registered and SHALL be 1 if and only if the state is RUN; it never glitches high in any other state.
REQ-017 Latency: RN SHALL rise on exactly the (SYNC_STAGES+STRETCH_CYCLES)-th CLK rising edge after R falls (10 with the defaults).
REQ-018 DONE SHALL be 1 for exactly the one cycle following the STRETCH->RUN edge, and 0 otherwise.
REQ-019 In RUN, REQ=1 on an edge SHALL move the state to STRETCH, drive RN low at that edge, and clear the counter; the sync chain is untouched.
REQ-020 REQ SHALL be ignored in RESET, SYNC and STRETCH; a stretch in progress is neither extended nor restarted.
REQ-021 If REQ is held high continuously, the block SHALL re-enter STRETCH on the edge after each DONE, giving RN one cycle high per period.
REQ-022 The counter SHALL never wrap; it saturates at STRETCH_CYCLES-1 until the state changes.
REQ-023 BUSY SHALL equal the inverse of RN in every cycle.

Reset
REQ-024 R high SHALL immediately, without waiting for CLK, force RN=0, BUSY=1, DONE=0, STATE=RESET, the chain to all 0 and the counter to 0.
REQ-025 R asserted mid-SYNC, mid-STRETCH or in RUN SHALL abort the sequence; after release the full latency of REQ-017 applies again.
REQ-026 A pulse on R of any width, including one shorter than a CLK period, SHALL produce the full reset sequence.

Configuration
REQ-027 Macro RSTGEN_SOFTREQ_EN defined: REQ behaves per REQ-019..REQ-021.
REQ-028 Macro RSTGEN_SOFTREQ_EN undefined: the REQ port remains but is ignored, RUN is terminal until R asserts, and DONE occurs only once per R release.

Verification
REQ-029 Defaults; R=1 for 3 cycles, then low -> RN=0 and STATE 0/1/2 in turn; RN=1, DONE=1 on edge 10; DONE=0 on edge 11.
REQ-030 In RUN, R pulse of 0.3 CLK period between edges -> RN=0 within the same period; RN=1 again exactly 10 edges later.
REQ-031 SOFTREQ_EN; in RUN, REQ=1 for 1 cycle -> RN=0 at that edge; RN=1 and DONE=1 after 8 edges.
REQ-032 SOFTREQ_EN; REQ pulsed during STRETCH edge 4 -> RN still rises at edge 8 of the stretch.
REQ-033 SOFTREQ_EN undefined; REQ held high in RUN for 20 cycles -> RN stays 1, DONE stays 0.
REQ-034 SYNC_STAGES=3, STRETCH_CYCLES=1; R released -> RN=1 on edge 4; R reasserted at edge 2 -> RN stays 0, STATE=RESET.
